// File: rtl/velocity_cell_stream_ctrl_pkg.sv
// Shared definitions for the cell velocity stream controller: state encoding,
// fixed RAM layout and the velocity word field positions.
package velocity_cell_stream_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_CNT   = 3'd1,
        ST_CNT_WAIT = 3'd2,
        ST_STREAM   = 3'd3,
        ST_WRITE    = 3'd4,
        ST_FIN      = 3'd5
    } vel_state_e;

    localparam int unsigned VEL_COUNT_ADDR = 0;
    localparam int unsigned FIFO_DEPTH     = 2;

    // velocity word layout {vz, vy, vx}
    localparam int unsigned VX_LSB = 0;
    localparam int unsigned VX_MSB = 31;
    localparam int unsigned VY_LSB = 32;
    localparam int unsigned VY_MSB = 63;
    localparam int unsigned VZ_LSB = 64;
    localparam int unsigned VZ_MSB = 95;

endpackage

// File: rtl/vel_skid_fifo2.sv
// Two-entry FIFO holding {index, velocity} pairs between the RAM read port
// and the output stream; the head entry is presented from registers.
module vel_skid_fifo2
    import velocity_cell_stream_ctrl_pkg::*;
#(
    parameter int unsigned IW = 8,
    parameter int unsigned DW = 96
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [IW-1:0] push_index,
    input  logic [DW-1:0] push_velocity,
    input  logic          pop,
    output logic [IW-1:0] head_index,
    output logic [DW-1:0] head_velocity,
    output logic          full,
    output logic          empty,
    output logic [1:0]    count
);

    logic [IW-1:0] idx_q [2];
    logic [DW-1:0] vel_q [2];
    logic          wr_sel;
    logic          rd_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                idx_q[i] <= '0;
                vel_q[i] <= '0;
            end
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                idx_q[wr_sel] <= push_index;
                vel_q[wr_sel] <= push_velocity;
                wr_sel        <= ~wr_sel;
            end
            if (pop) begin
                rd_sel <= ~rd_sel;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_index    = idx_q[rd_sel];
    assign head_velocity = vel_q[rd_sel];
    assign full          = (count == 2'(FIFO_DEPTH));
    assign empty         = (count == 2'd0);

endmodule

// File: rtl/velocity_cell_stream_ctrl.sv
// Sequencer for one cell velocity RAM: a read pass streams the stored words
// out with backpressure, a write pass stores the updated words back in order.
module velocity_cell_stream_ctrl
    import velocity_cell_stream_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 96,
    parameter int unsigned PARTICLE_NUM = 220,
    parameter int unsigned ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_rd,
    input  logic                  start_wr,
    output logic                  busy,
    output logic                  done,
    output logic                  count_err,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_velocity,
    output logic [ADDR_WIDTH-1:0] out_index,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [DATA_WIDTH-1:0] wb_velocity
);

    localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

    vel_state_e            state;
    logic [ADDR_WIDTH-1:0] cell_count;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_k;
    logic                  inflight;
    logic [ADDR_WIDTH-1:0] inflight_idx;

    logic [ADDR_WIDTH-1:0] cnt_raw;
    logic [ADDR_WIDTH-1:0] cnt_clamped;
    logic                  cnt_over;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [1:0]            fifo_count;
    logic [1:0]            occ_after_pop;
    logic [1:0]            pending;
    logic                  fifo_push;
    logic                  pop;
    logic                  last_pop;
    logic                  rd_issue;
    logic                  wr_fire;

    assign cnt_raw     = mem_q[ADDR_WIDTH-1:0];
    assign cnt_over    = (cnt_raw > MAX_COUNT);
    assign cnt_clamped = cnt_over ? MAX_COUNT : cnt_raw;

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign last_pop  = pop && (out_index == cell_count - ADDR_WIDTH'(1));
    assign fifo_push = inflight & ~fifo_full;

    // A slot freed by this cycle's pop counts as available, so a held-high
    // out_ready sustains one word per cycle.
    assign occ_after_pop = fifo_count - {1'b0, pop};
    assign pending       = occ_after_pop + {1'b0, inflight};
    assign rd_issue      = (state == ST_STREAM) && (pending < 2'd2) && (rd_ptr <= cell_count);

    assign wb_ready       = (state == ST_WRITE);
    assign wr_fire        = wb_valid & wb_ready;
    assign busy           = (state != ST_IDLE);
    assign done           = (state == ST_FIN);
    assign particle_count = cell_count;

    vel_skid_fifo2 #(
        .IW (ADDR_WIDTH),
        .DW (DATA_WIDTH)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .push          (fifo_push),
        .push_index    (inflight_idx),
        .push_velocity (mem_q),
        .pop           (pop),
        .head_index    (out_index),
        .head_velocity (out_velocity),
        .full          (fifo_full),
        .empty         (fifo_empty),
        .count         (fifo_count)
    );

    // RAM port: count read, streaming reads and write-back; silent in reset
    always_comb begin
        mem_rden    = 1'b0;
        mem_wren    = 1'b0;
        mem_address = '0;
        mem_data    = '0;
        if (!rst) begin
            if (state == ST_RD_CNT) begin
                mem_rden    = 1'b1;
                mem_address = ADDR_WIDTH'(VEL_COUNT_ADDR);
            end else if (rd_issue) begin
                mem_rden    = 1'b1;
                mem_address = rd_ptr;
            end else if (wr_fire) begin
                mem_wren    = 1'b1;
                mem_address = wr_k + ADDR_WIDTH'(1);
                mem_data    = wb_velocity;
            end
        end
    end

    // pass sequencing and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cell_count   <= '0;
            count_err    <= 1'b0;
            rd_ptr       <= '0;
            wr_k         <= '0;
            inflight     <= 1'b0;
            inflight_idx <= '0;
        end else begin
            inflight <= rd_issue;
            if (rd_issue) begin
                inflight_idx <= rd_ptr - ADDR_WIDTH'(1);
                rd_ptr       <= rd_ptr + ADDR_WIDTH'(1);
            end
            unique case (state)
                ST_IDLE: begin
                    if (start_rd) begin
                        count_err <= 1'b0;
                        state     <= ST_RD_CNT;
                    end else if (start_wr) begin
                        wr_k  <= '0;
                        state <= (cell_count == '0) ? ST_FIN : ST_WRITE;
                    end
                end
                ST_RD_CNT: state <= ST_CNT_WAIT;
                ST_CNT_WAIT: begin
                    cell_count <= cnt_clamped;
                    if (cnt_over) begin
                        count_err <= 1'b1;
                    end
                    rd_ptr <= ADDR_WIDTH'(1);
                    state  <= (cnt_clamped == '0) ? ST_FIN : ST_STREAM;
                end
                ST_STREAM: begin
                    if (last_pop) begin
                        state <= ST_FIN;
                    end
                end
                ST_WRITE: begin
                    if (wr_fire) begin
                        wr_k <= wr_k + ADDR_WIDTH'(1);
                        if (wr_k == cell_count - ADDR_WIDTH'(1)) begin
                            state <= ST_FIN;
                        end
                    end
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_velocity_cell_stream_ctrl.sv
// Bench for velocity_cell_stream_ctrl: a RAM model plus a reference copy of
// the memory contents from which every expected stream and write is derived.
module tb_velocity_cell_stream_ctrl;

    logic        clk;
    logic        rst;
    logic        start_rd;
    logic        start_wr;
    logic        busy;
    logic        done;
    logic        count_err;
    logic [7:0]  particle_count;
    logic [7:0]  mem_address;
    logic [95:0] mem_data;
    logic        mem_rden;
    logic        mem_wren;
    logic [95:0] mem_q;
    logic        out_valid;
    logic        out_ready;
    logic [95:0] out_velocity;
    logic [7:0]  out_index;
    logic        wb_valid;
    logic        wb_ready;
    logic [95:0] wb_velocity;

    logic        load_en;
    logic [7:0]  load_addr;
    logic [95:0] load_data;
    logic [95:0] ram     [0:255];
    logic [95:0] ref_mem [0:255];
    int          ref_count;
    int          cyc;
    int          vectors;
    int          errors;

    velocity_cell_stream_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start_rd       (start_rd),
        .start_wr       (start_wr),
        .busy           (busy),
        .done           (done),
        .count_err      (count_err),
        .particle_count (particle_count),
        .mem_address    (mem_address),
        .mem_data       (mem_data),
        .mem_rden       (mem_rden),
        .mem_wren       (mem_wren),
        .mem_q          (mem_q),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_velocity   (out_velocity),
        .out_index      (out_index),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_velocity    (wb_velocity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // single-port RAM, one cycle read latency
    always @(posedge clk) begin
        if (mem_rden) mem_q <= ram[mem_address];
        if (mem_wren) ram[mem_address] <= mem_data;
        if (load_en)  ram[load_addr] <= load_data;
    end

    function automatic logic [95:0] rand_word();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic set_word(input int addr, input logic [95:0] val);
        load_en   = 1'b1;
        load_addr = 8'(addr);
        load_data = val;
        ref_mem[addr] = val;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic load_cell(input logic [7:0] cnt_field, input int nwords);
        set_word(0, {$urandom, $urandom, 24'($urandom), cnt_field});
        for (int i = 1; i <= nwords; i++) set_word(i, rand_word());
    endtask

    task automatic load_basic();
        set_word(0, 96'd3);
        set_word(1, {$urandom, $urandom, 24'($urandom), 8'hA1});
        set_word(2, {$urandom, $urandom, 24'($urandom), 8'hA2});
        set_word(3, {$urandom, $urandom, 24'($urandom), 8'hA3});
    endtask

    // ready_mode: 0 always ready, 1 pattern 1,0,0, 2 random
    // wr_mode:    0 none, 1 start_wr with start_rd, 2 start_wr mid-stream
    task automatic run_read_pass(input int ready_mode, input int wr_mode);
        logic [95:0] exp_vel [$];
        logic [7:0]  exp_idx [$];
        logic [95:0] prev_vel;
        logic [7:0]  prev_idx;
        int raw, n, t0, first_cyc, last_hs, done_cyc, exp_done, issued, delivered;
        bit exp_err, prev_stall, hs;
        raw     = int'(ref_mem[0][7:0]);
        exp_err = (raw > 219);
        n       = exp_err ? 219 : raw;
        for (int i = 1; i <= n; i++) begin
            exp_vel.push_back(ref_mem[i]);
            exp_idx.push_back(8'(i - 1));
        end
        t0 = cyc; first_cyc = -1; last_hs = -1; done_cyc = -1;
        issued = 0; delivered = 0; prev_stall = 0; prev_vel = '0; prev_idx = '0;
        for (int c = 0; c < 1000 && done_cyc < 0; c++) begin
            start_rd = (c == 0);
            start_wr = (wr_mode == 1 && c == 0) || (wr_mode == 2 && c == 6);
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((c % 3) == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            hs = out_valid && out_ready;
            vectors++;
            if (mem_wren !== 1'b0) begin
                errors++; $display("FAIL rd_no_wren cyc=%0d got=%b exp=0", cyc, mem_wren);
            end
            if (c == 1) begin
                vectors++;
                if ({busy, mem_rden, mem_address} !== {1'b1, 1'b1, 8'd0}) begin
                    errors++; $display("FAIL rd_count_read got busy/rden/addr=%b/%b/%0d exp=1/1/0", busy, mem_rden, mem_address);
                end
            end
            if (mem_rden && cyc > t0 + 1) begin
                vectors++;
                if ((issued - delivered - int'(hs)) >= 2 || mem_address !== 8'(issued + 1)) begin
                    errors++; $display("FAIL rd_issue cyc=%0d got addr=%0d pending=%0d exp addr=%0d pending<2",
                                       cyc, mem_address, issued - delivered - int'(hs), issued + 1);
                end
                issued++;
            end
            if (prev_stall) begin
                vectors++;
                if (!out_valid || out_velocity !== prev_vel || out_index !== prev_idx) begin
                    errors++; $display("FAIL rd_stall_hold got v=%b idx=%0d vel=%0h exp v=1 idx=%0d vel=%0h",
                                       out_valid, out_index, out_velocity, prev_idx, prev_vel);
                end
            end
            if (out_valid) begin
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    vectors++;
                    if (n == 0 || cyc != t0 + 5) begin
                        errors++; $display("FAIL rd_first_valid got cyc=%0d exp=%0d (n=%0d)", cyc - t0, 5, n);
                    end
                end
                if (out_ready) begin
                    vectors++;
                    if (exp_vel.size() == 0) begin
                        errors++; $display("FAIL rd_extra_word got idx=%0d exp=none", out_index);
                    end else begin
                        if (out_velocity !== exp_vel[0] || out_index !== exp_idx[0]) begin
                            errors++; $display("FAIL rd_word got idx=%0d vel=%0h exp idx=%0d vel=%0h",
                                               out_index, out_velocity, exp_idx[0], exp_vel[0]);
                        end
                        void'(exp_vel.pop_front());
                        void'(exp_idx.pop_front());
                    end
                    delivered++;
                    last_hs = cyc;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_vel   = out_velocity;
            prev_idx   = out_index;
            if (done) done_cyc = cyc;
            @(posedge clk); #1;
        end
        start_rd = 1'b0;
        start_wr = 1'b0;
        exp_done = (n == 0) ? t0 + 3 : ((ready_mode == 0) ? t0 + 5 + n : last_hs + 1);
        vectors++;
        if (done_cyc != exp_done) begin
            errors++; $display("FAIL rd_done_time got=%0d exp=%0d (rel T)", done_cyc - t0, exp_done - t0);
        end
        vectors++;
        if (exp_vel.size() != 0 || delivered != n || issued != n) begin
            errors++; $display("FAIL rd_word_count got delivered=%0d issued=%0d exp=%0d", delivered, issued, n);
        end
        vectors++;
        if (particle_count !== 8'(n) || count_err !== exp_err) begin
            errors++; $display("FAIL rd_count got cnt=%0d err=%b exp cnt=%0d err=%b", particle_count, count_err, n, exp_err);
        end
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rd_idle_after got busy/done/valid=%b%b%b exp=000", busy, done, out_valid);
        end
        ref_count = n;
    endtask

    // valid_mode: 0 wb_valid held high, 1 random
    task automatic run_write_pass(input int valid_mode);
        logic [95:0] words [$];
        int n, t0, k, last_wr, done_cyc, exp_done;
        n = ref_count;
        for (int i = 0; i < n; i++) words.push_back(rand_word());
        t0 = cyc; k = 0; last_wr = -1; done_cyc = -1;
        for (int c = 0; c < 1000 && done_cyc < 0; c++) begin
            start_wr    = (c == 0);
            wb_valid    = (valid_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            wb_velocity = (k < n) ? words[k] : rand_word();
            @(negedge clk);
            if (c == 1) begin
                vectors++;
                if (wb_ready !== (n > 0)) begin
                    errors++; $display("FAIL wr_ready_rise got=%b exp=%b", wb_ready, n > 0);
                end
            end
            vectors++;
            if (mem_rden !== 1'b0) begin
                errors++; $display("FAIL wr_no_rden cyc=%0d got=%b exp=0", cyc, mem_rden);
            end
            vectors++;
            if (wb_valid && wb_ready) begin
                if (k >= n) begin
                    errors++; $display("FAIL wr_extra got k=%0d exp<%0d", k, n);
                end else begin
                    if (mem_wren !== 1'b1 || mem_address !== 8'(k + 1) || mem_data !== words[k]) begin
                        errors++; $display("FAIL wr_word got wren=%b addr=%0d data=%0h exp wren=1 addr=%0d data=%0h",
                                           mem_wren, mem_address, mem_data, k + 1, words[k]);
                    end
                    ref_mem[k + 1] = words[k];
                end
                k++;
                last_wr = cyc;
            end else if (mem_wren !== 1'b0) begin
                errors++; $display("FAIL wr_idle_wren cyc=%0d got=1 exp=0", cyc);
            end
            if (done) done_cyc = cyc;
            @(posedge clk); #1;
        end
        start_wr = 1'b0;
        wb_valid = 1'b0;
        exp_done = (n == 0) ? t0 + 1 : last_wr + 1;
        vectors++;
        if (done_cyc != exp_done || k != n) begin
            errors++; $display("FAIL wr_done got done=%0d writes=%0d exp done=%0d writes=%0d", done_cyc - t0, k, exp_done - t0, n);
        end
        if (valid_mode == 0 && n > 0) begin
            vectors++;
            if (last_wr != t0 + n) begin
                errors++; $display("FAIL wr_back_to_back got last=%0d exp=%0d", last_wr - t0, n);
            end
        end
        vectors++;
        if (busy !== 1'b0 || wb_ready !== 1'b0) begin
            errors++; $display("FAIL wr_idle_after got busy=%b ready=%b exp=00", busy, wb_ready);
        end
    endtask

    task automatic check_all_zero(input int tag);
        @(negedge clk);
        vectors++;
        if ({busy, done, count_err, particle_count, mem_address, mem_data, mem_rden, mem_wren,
             out_valid, out_velocity, out_index, wb_ready} !== '0) begin
            errors++; $display("FAIL reset_outputs tag=%0d got busy=%b done=%b err=%b cnt=%0d addr=%0d rden=%b wren=%b valid=%b idx=%0d wbr=%b exp all 0",
                               tag, busy, done, count_err, particle_count, mem_address, mem_rden, mem_wren,
                               out_valid, out_index, wb_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({mem_rden, mem_wren, busy, out_valid} !== 4'b0) begin
            errors++; $display("FAIL reset_held got=%b exp=0000", {mem_rden, mem_wren, busy, out_valid});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        check_all_zero(0);
        ref_count = 0;
        run_write_pass(0);
    endtask

    task automatic test_read_basic();
        load_basic();
        run_read_pass(0, 0);
    endtask

    task automatic test_backpressure();
        load_cell(8'd5, 5);
        run_read_pass(1, 0);
        load_cell(8'd12, 12);
        run_read_pass(2, 0);
    endtask

    task automatic test_count_edges();
        load_cell(8'd0, 0);
        run_read_pass(0, 0);
        load_cell(8'd250, 219);
        run_read_pass(0, 0);
        load_cell(8'd7, 7);
        run_read_pass(2, 0);
    endtask

    task automatic test_write_pass();
        load_basic();
        run_read_pass(0, 0);
        run_write_pass(0);
        run_read_pass(0, 0);
        run_write_pass(1);
        run_read_pass(2, 0);
    endtask

    task automatic test_simultaneous();
        run_read_pass(0, 1);
        run_read_pass(1, 2);
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 30);
            load_cell(8'(n), n);
            run_read_pass(2, 0);
            run_write_pass(1);
            run_read_pass(int'($urandom_range(0, 2)), 0);
        end
    endtask

    task automatic test_reset_mid_pass();
        logic [95:0] w;
        load_cell(8'd10, 10);
        start_rd  = 1'b1;
        out_ready = 1'b1;
        repeat (7) begin
            @(posedge clk); #1;
            start_rd = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({mem_rden, mem_wren} !== 2'b00) begin
            errors++; $display("FAIL rst_stream_mem got rden=%b wren=%b exp=00", mem_rden, mem_wren);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        check_all_zero(1);
        ref_count = 0;

        run_read_pass(0, 0);
        start_wr = 1'b1;
        wb_valid = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk); #1;
            start_wr    = 1'b0;
            w           = rand_word();
            wb_velocity = w;
            @(negedge clk);
            vectors++;
            if (mem_wren !== 1'b1 || mem_address !== 8'(c) || mem_data !== w) begin
                errors++; $display("FAIL rst_write_pre got wren=%b addr=%0d exp wren=1 addr=%0d", mem_wren, mem_address, c);
            end
            ref_mem[c] = w;
        end
        @(posedge clk); #1;
        rst         = 1'b1;
        wb_velocity = rand_word();
        @(negedge clk);
        vectors++;
        if ({mem_rden, mem_wren} !== 2'b00) begin
            errors++; $display("FAIL rst_write_mem got rden=%b wren=%b exp=00", mem_rden, mem_wren);
        end
        @(posedge clk); #1;
        rst      = 1'b0;
        wb_valid = 1'b0;
        check_all_zero(2);
        ref_count = 0;

        load_basic();
        run_read_pass(0, 0);
    endtask

    initial begin
        rst = 1'b1; start_rd = 1'b0; start_wr = 1'b0; out_ready = 1'b0;
        wb_valid = 1'b0; wb_velocity = '0; load_en = 1'b0; load_addr = '0; load_data = '0;
        vectors = 0; errors = 0; ref_count = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_read_basic();
        test_backpressure();
        test_count_edges();
        test_write_pass();
        test_simultaneous();
        test_random();
        test_reset_mid_pass();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/velocity_cell_stream_ctrl.md
# velocity_cell_stream_ctrl

Sequencing controller for one per-cell velocity memory. It runs two kinds of pass over the memory:
- **Read pass:** reads the particle count at address 0, then streams every velocity word `{vz, vy, vx}` to the motion-update pipeline. The stream uses a valid/ready handshake with backpressure.
- **Write pass:** accepts the updated velocities back from the pipeline and writes them into the same addresses, in order.

The block sits between the cell velocity RAM (single port, 1-cycle read latency) and the velocity cache / motion-update logic.

## Interface
- `DATA_WIDTH`, 96: velocity word width, `{vz, vy, vx}`, 32 bits each.
- `PARTICLE_NUM`, 220: RAM depth. Address 0 holds the count, so at most `PARTICLE_NUM-1` particles.
- `ADDR_WIDTH`, 8: RAM address width.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start_rd` in 1: single-cycle pulse that requests a read pass.
- `start_wr` in 1: single-cycle pulse that requests a write pass.
- `busy` out 1: high while the block is in any state other than IDLE.
- `done` out 1: one-cycle pulse when a pass completes.
- `count_err` out 1: sticky; set when the stored count exceeds `PARTICLE_NUM-1`; cleared by `rst` or `start_rd`.
- `particle_count` out `ADDR_WIDTH`: count latched during the last read pass, after clamping.
- `mem_address` out `ADDR_WIDTH`: RAM address.
- `mem_data` out `DATA_WIDTH`: RAM write data.
- `mem_rden` out 1: RAM read enable.
- `mem_wren` out 1: RAM write enable.
- `mem_q` in `DATA_WIDTH`: RAM read data, valid 1 cycle after `mem_rden`.
- `out_valid` out 1: output stream has a word.
- `out_ready` in 1: consumer accepts the word this cycle.
- `out_velocity` out `DATA_WIDTH`: streamed velocity word.
- `out_index` out `ADDR_WIDTH`: particle index of `out_velocity`, 0-based (RAM address − 1).
- `wb_valid` in 1: write-back word is present.
- `wb_ready` out 1: block accepts the write-back word this cycle.
- `wb_velocity` in `DATA_WIDTH`: updated velocity word.

## Operation
**Reset values:** every output is 0, the state is IDLE, and the output FIFO is empty.
- `mem_rden` and `mem_wren` are forced low in any cycle where `rst` is high, including a reset that arrives mid-pass.
- After reset, no stale `out_valid` and no stale write may appear.

**States:** IDLE, RD_CNT, CNT_WAIT, STREAM, WRITE, FIN.
- **IDLE:**
  - `start_rd` → RD_CNT.
  - `start_wr` → WRITE.
  - Both asserted together: the read pass wins and `start_wr` is dropped.
  - Start pulses that arrive while `busy` is high are ignored.
- **RD_CNT:** drive `mem_rden=1`, `mem_address=0`; then go to CNT_WAIT.
- **CNT_WAIT:** latch `mem_q[ADDR_WIDTH-1:0]` into the count.
  - If the value exceeds `PARTICLE_NUM-1`, clamp it to `PARTICLE_NUM-1` and set `count_err`.
  - Count 0 → FIN. Otherwise → STREAM, with the read pointer at 1.
- **STREAM:** the block buffers read data in a 2-entry output FIFO.
  - A read is issued (`mem_rden=1`, `mem_address`=pointer, pointer+1) only when FIFO occupancy + reads in flight < 2, and the pointer ≤ count.
  - `mem_q` is pushed into the FIFO the cycle after each issued read. `out_index` is carried with the data.
  - The FIFO head drives `out_velocity` and `out_index`. A pop happens on `out_valid & out_ready`.
  - The state moves to FIN in the cycle after the handshake of index count−1.
- **WRITE:** `wb_ready=1` until count words have been accepted.
  - Each `wb_valid & wb_ready` drives `mem_wren=1`, `mem_address` = k+1 (k counts from 0), and `mem_data=wb_velocity` in that same cycle.
  - The write pass uses the count latched by the most recent read pass. If that count is 0, the state goes directly to FIN.
  - The state moves to FIN in the cycle after the last write.
- **FIN:** `done=1` for one cycle, then → IDLE.

**Outputs:** memory controls and `wb_ready` are combinational from the state and counters. `out_valid`, `out_velocity` and `out_index` come from FIFO registers.

**Widths:** the pointer and k are `ADDR_WIDTH` bits. No wrap is possible, because the count is clamped.

## Timing
- `start_rd` sampled at edge T: RD_CNT occupies cycle T+1, CNT_WAIT cycle T+2, and the first data read is issued in cycle T+3.
- The first `out_valid` rises in cycle T+5.
- With `out_ready` held high, the stream delivers one word per cycle with no gaps.
- When `out_ready` drops, at most 2 words are buffered. `out_velocity` and `out_index` hold stable while `out_valid & !out_ready`.
- Write pass: `wb_ready` rises in cycle T+1. One write per cycle while `wb_valid` is held high.
- `done` is asserted exactly 1 cycle after the final handshake or write.

## Structure
- A shared package/include holds:
  - the state encodings;
  - `VEL_COUNT_ADDR = 0`;
  - the field slices `VX = [31:0]`, `VY = [63:32]`, `VZ = [95:64]`.
- One natural sub-module: `vel_skid_fifo2`, a 2-entry FIFO of `{index, velocity}` with `push`, `pop`, `full`, `empty` and `count` signals.
- The FSM and counters live in the top module.

## Test plan
- **Read, no backpressure:** RAM[0]=3, RAM[1..3]=0x…A1/A2/A3, `out_ready`=1, `start_rd` → three consecutive `out_valid` words A1, A2, A3 with `out_index` 0, 1, 2 starting at T+5; `done` pulse at T+8; `particle_count`=3.
- **Read with backpressure:** count 5, `out_ready` toggled 1,0,0,1,… → every word delivered exactly once and in order; word held stable while stalled; `mem_rden` never issued with FIFO occupancy + in-flight = 2.
- **Count edge cases:**
  - count 0 → no `out_valid`, `done` at T+3.
  - count 250 → `count_err`=1, `particle_count`=219, 219 words streamed.
- **Write pass:** after a read of count 3, `start_wr`, `wb_valid` high with B1, B2, B3 → writes to addresses 1, 2, 3 in consecutive cycles; a subsequent read pass streams B1 to B3.
- **Simultaneous starts:** `start_rd` and `start_wr` in the same cycle → read pass only, no `mem_wren`. A `start_wr` during STREAM is ignored.
- **Reset mid-pass:** `rst` in the middle of STREAM and in the middle of WRITE → `mem_wren` and `mem_rden` are 0 in the `rst` cycle; all outputs are 0 the next cycle; the state is IDLE; a subsequent read pass behaves exactly as in the first scenario.
